// File: rtl/prm_chk_pkg.sv
// Shared types and constants for the PRM edge obstacle-check sequencer.
package prm_chk_pkg;
  localparam int OBS_W         = 15;
  localparam int NUM_EDGES_DEF = 256;
  localparam int GROUP_DEF     = 16;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/prm_grp_popcnt.sv
// Popcount of one GROUP-wide edge_mask slice, counting only lanes marked valid.
module prm_grp_popcnt import prm_chk_pkg::*; #(
  parameter int GROUP = GROUP_DEF,
  parameter int PW    = clog2(GROUP + 1)
) (
  input  logic [GROUP-1:0] i_data,
  input  logic [GROUP-1:0] i_vmask,
  output logic [PW-1:0]    o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < GROUP; i++) o_cnt = o_cnt + PW'(i_data[i] & i_vmask[i]);
  end
endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Drives one obstacle code across the edge-check bank group by group and
// returns the collision bitmap plus blocked-edge count to the planner.
module prm_edge_scan_ctrl import prm_chk_pkg::*; #(
  parameter int NUM_EDGES = NUM_EDGES_DEF,
  parameter int GROUP     = GROUP_DEF,
  parameter int OBS_W     = prm_chk_pkg::OBS_W,
  localparam int NG = (NUM_EDGES + GROUP - 1) / GROUP,
  localparam int GW = (NG > 1) ? clog2(NG) : 1,
  localparam int CW = clog2(NUM_EDGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 obs_valid,
  output logic                 obs_ready,
  input  logic [OBS_W-1:0]     obs_code,
  input  logic                 abort,
  output logic [OBS_W-1:0]     chk_obs,
  output logic [GW-1:0]        chk_grp,
  output logic                 chk_en,
  input  logic [GROUP-1:0]     chk_mask,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_EDGES-1:0] res_map,
  output logic [CW-1:0]        res_blocked
);
  localparam int PW = clog2(GROUP + 1);

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  state_e               r_state, w_state_nxt;
  logic [OBS_W-1:0]     r_obs;
  logic [GW-1:0]        r_grp;
  logic                 r_en;
  logic [NUM_EDGES-1:0] r_map;
  logic [CW-1:0]        r_cnt;
  logic [GROUP-1:0]     w_vmask;
  logic [PW-1:0]        w_pc;
  logic                 w_last;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];

  assign w_last = (r_grp == GW'(NG - 1));

  // Lanes past NUM_EDGES in the final group carry no edge.
  always_comb begin
    w_vmask = '0;
    for (int i = 0; i < GROUP; i++) w_vmask[i] = (int'(r_grp) * GROUP + i) < NUM_EDGES;
  end

  prm_grp_popcnt #(.GROUP(GROUP), .PW(PW)) u_popcnt (
    .i_data (chk_mask),
    .i_vmask(w_vmask),
    .o_cnt  (w_pc)
  );

  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (obs_valid) w_state_nxt = SCAN;
      SCAN:    if (abort) w_state_nxt = IDLE;
               else if (w_last) w_state_nxt = DONE;
      DONE:    if (res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_obs <= '0;
      r_grp <= '0;
      r_en  <= 1'b0;
      r_map <= '0;
      r_cnt <= '0;
    end else if (r_state == IDLE && obs_valid) begin
      r_obs <= obs_code;
      r_grp <= '0;
      r_en  <= 1'b1;
      r_map <= '0;
      r_cnt <= '0;
    end else if (r_state == SCAN) begin
      if (abort) begin
        r_en  <= 1'b0;
        r_grp <= '0;
      end else begin
        for (int e = 0; e < NUM_EDGES; e++)
          if (GW'(e / GROUP) == r_grp) r_map[e] <= chk_mask[e % GROUP];
        r_cnt <= r_cnt + CW'(w_pc);
        if (w_last) begin
          r_en  <= 1'b0;
          r_grp <= '0;
        end else begin
          r_grp <= r_grp + GW'(1);
        end
      end
    end
  end

  assign obs_ready   = (r_state == IDLE);
  assign res_valid   = (r_state == DONE);
  assign chk_obs     = r_obs;
  assign chk_grp     = r_grp;
  assign chk_en      = r_en;
  assign res_map     = r_map;
  assign res_blocked = r_cnt;
endmodule

// File: doc/prm_edge_scan_ctrl.md
Name: prm_edge_scan_ctrl

Overview:
Sequencer for the bank of PRM edge obstacle-check cells. Each cell maps a 15-bit obstacle/voxel code (A..O) to one edge_mask bit; 1 = edge collides.
The block accepts one obstacle code per scan and drives it to the check bank one group of edges per cycle. It assembles the per-edge collision bitmap and a blocked-edge count, then hands both to the roadmap planner over a valid/ready handshake.

Parameters:
NUM_EDGES, 256, number of edge-check cells in the bank (1..1024)
GROUP, 16, edge_mask bits returned by the bank per cycle (power of 2, ≤ NUM_EDGES)
OBS_W, 15, obstacle code width (bit 0 = A ... bit 14 = O)
NG (localparam), ceil(NUM_EDGES/GROUP), group count; GW = max(1, clog2(NG)); CW = clog2(NUM_EDGES+1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
obs_valid  in  1  obstacle code offered
obs_ready  out  1  controller can accept a code
obs_code  in  OBS_W  obstacle code
abort  in  1  cancel the scan in progress
chk_obs  out  OBS_W  code driven to the check bank (registered)
chk_grp  out  GW  group select to the check bank (registered)
chk_en  out  1  chk_grp valid this cycle
chk_mask  in  GROUP  combinational bank result for chk_grp; bit i = edge chk_grp*GROUP+i
res_valid  out  1  result available
res_ready  in  1  planner takes the result
res_map  out  NUM_EDGES  collision bitmap, 1 = blocked
res_blocked  out  CW  popcount of res_map

Behaviour:
- Reset (async assert, sync deassert inside the block): state IDLE.
  - obs_ready=1; res_valid=0; chk_en=0; chk_grp=0; chk_obs=0; res_map=0; res_blocked=0.
- States: IDLE, SCAN, DONE.
- IDLE: obs_ready=1. On obs_valid in this state:
  - obs_code is latched into chk_obs; chk_grp is set to 0; chk_en is set to 1.
  - Map and count are cleared; next state is SCAN.
- SCAN: obs_ready=0.
  - Each cycle, chk_mask is sampled into map[chk_grp*GROUP +: GROUP] and its popcount is added to the count.
  - Bits at indices ≥ NUM_EDGES in the last group are forced to 0 before both store and count.
  - chk_grp increments by 1. When chk_grp == NG-1 is sampled: chk_en←0, chk_grp←0, next state DONE.
- DONE: res_valid=1; res_map and res_blocked are held stable until res_valid & res_ready, then next state is IDLE.
  - A new code cannot be accepted in the same cycle as the result is consumed; obs_ready rises the cycle after.
- Latency: handshake accepted at cycle 0 → groups 0..NG-1 driven at cycles 1..NG → res_valid at cycle NG+1. Throughput is one scan per NG+2 cycles with res_ready held high.
- chk_obs holds the latched code for the whole scan; a change on obs_code during SCAN has no effect.
- abort in SCAN: next state IDLE; chk_en←0; map/count are left as-is but never presented (res_valid stays 0).
- abort in IDLE or DONE is ignored; a DONE result is never dropped.
- Count arithmetic: unsigned, CW bits, cannot overflow because the maximum is NUM_EDGES.
- NG == 1: SCAN lasts exactly 1 cycle.
- rst_n asserted mid-scan: immediate return to reset values; no partial result is emitted.

Decomposition:
- Shared package prm_chk_pkg:
  - OBS_W
  - state enum (IDLE, SCAN, DONE)
  - clog2 function
  - default NUM_EDGES/GROUP
- One sub-module, prm_grp_popcnt: combinational GROUP-bit popcount with a valid-bit mask input, reused by the planner side.
- The check cells themselves stay outside this block.

Test Plan:
- NUM_EDGES=256, GROUP=16, bank model returns chk_mask=16'h0001 for every group; obs_code=15'h4A3D:
  - chk_grp must read 0..15 on cycles 1..16.
  - res_valid must rise on cycle 17.
  - res_map must have bits 0,16,...,240 set; res_blocked=16.
- NUM_EDGES=200, GROUP=16, bank returns all-ones:
  - Last group bits 200..207 forced 0; res_map[199:0] all 1; res_blocked=200.
- Back-pressure: res_ready low for 10 cycles after res_valid:
  - res_map and res_blocked stay stable; obs_ready=0 throughout.
  - obs_ready rises 1 cycle after the handshake.
- abort asserted at chk_grp=5:
  - Next cycle IDLE with chk_en=0; no res_valid.
  - The following scan with a zero-returning bank yields res_blocked=0.
- obs_code toggled every cycle during SCAN: chk_obs stays at the accepted value.
- rst_n pulsed low for 1 cycle mid-SCAN:
  - All outputs at reset values asynchronously.
  - A fresh scan completes normally.
